// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier datapath among N_REQ requesters.
// Sequences load/add/shift strobes and returns the captured product over a held handshake.
module mult_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_m,
  input  logic [N_REQ*W-1:0]         req_q,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [2*W-1:0]             rsp_product,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       dp_load,
  output logic                       dp_add,
  output logic                       dp_shift,
  output logic [W-1:0]               dp_m,
  output logic [W-1:0]               dp_q,
  input  logic                       dp_q0,
  input  logic [2*W-1:0]             dp_aq
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAdd,
    StShift,
    StCapture,
    StResp
  } state_e;

  state_e           state_q;
  logic [IdW-1:0]   last_gnt_q;
  logic [IdW-1:0]   gnt_id_q;
  logic [CntW-1:0]  cnt_q;
  logic [2*W-1:0]   result_q;
  logic [W-1:0]     dp_m_q;
  logic [W-1:0]     dp_q_q;

  logic             found;
  logic [IdW-1:0]   win;
  logic [IdW-1:0]   cand;

  // Scan starts just after the last grant so every pending requester gets its turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IdW'((int'(last_gnt_q) + k) % int'(N_REQ));
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    // Gated by reset so no accept pulse is shown while the block is being reset.
    if (state_q == StIdle && found && reset) begin
      req_ready[win] = 1'b1;
    end
    if (state_q == StResp) begin
      rsp_valid[gnt_id_q] = 1'b1;
    end
    dp_load     = (state_q == StLoad);
    dp_add      = (state_q == StAdd) && dp_q0;
    dp_shift    = (state_q == StShift);
    busy        = (state_q != StIdle);
    rsp_product = result_q;
    gnt_id      = gnt_id_q;
    dp_m        = dp_m_q;
    dp_q        = dp_q_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_gnt_q <= IdW'(N_REQ - 1);
      gnt_id_q   <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      dp_m_q     <= '0;
      dp_q_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            dp_m_q     <= req_m[win*W +: W];
            dp_q_q     <= req_q[win*W +: W];
            gnt_id_q   <= win;
            last_gnt_q <= win;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StAdd;
        end
        StAdd: begin
          state_q <= StShift;
        end
        StShift: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(W - 1)) begin
            state_q <= StCapture;
          end else begin
            state_q <= StAdd;
          end
        end
        StCapture: begin
          result_q <= dp_aq;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_ready[gnt_id_q]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: behavioural datapath, round-robin reference model and
// a scoreboard monitor that checks every response handshake independently of stimulus.
module tb_mult_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int           id;
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [2*W-1:0] p;
  } exp_t;

  logic               clock;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_m;
  logic [N*W-1:0]     req_q;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [2*W-1:0]     rsp_product;
  logic               busy;
  logic [1:0]         gnt_id;
  logic               dp_load;
  logic               dp_add;
  logic               dp_shift;
  logic [W-1:0]       dp_m;
  logic [W-1:0]       dp_q;
  logic               dp_q0;
  logic [2*W-1:0]     dp_aq;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] rq [N][$];   // driver operand queues {m,q}
  logic [2*W-1:0] mq [N][$];   // model copies
  exp_t           sb [$];
  int             model_last;
  logic [N-1:0]   rsp_hold;
  logic           rand_rsp;

  // Behavioural datapath
  logic [W-1:0]   a_r;
  logic [W-1:0]   q_r;
  logic           c_r;
  assign dp_q0 = q_r[0];
  assign dp_aq = {a_r, q_r};

  mult_scheduler #(.N_REQ(N), .W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_m       (req_m),
    .req_q       (req_q),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .busy        (busy),
    .gnt_id      (gnt_id),
    .dp_load     (dp_load),
    .dp_add      (dp_add),
    .dp_shift    (dp_shift),
    .dp_m        (dp_m),
    .dp_q        (dp_q),
    .dp_q0       (dp_q0),
    .dp_aq       (dp_aq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_op(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
    rq[i].push_back({m, q});
    mq[i].push_back({m, q});
  endtask

  // Reference arbitration: repeatedly serve the first non-empty requester after the last grant.
  task automatic plan();
    logic [2*W-1:0] e;
    exp_t x;
    bit any;
    do begin
      any = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (model_last + k) % N;
        if (!any && mq[idx].size() > 0) begin
          e = mq[idx].pop_front();
          x.id = idx;
          x.m  = e[2*W-1:W];
          x.q  = e[W-1:0];
          x.p  = (2*W)'(int'(x.m) * int'(x.q));
          sb.push_back(x);
          model_last = idx;
          any = 1;
        end
      end
    end while (any);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || pending() != 0 || busy) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
  endtask

  // Driver: pops operands on acceptance, presents the next pair, drives rsp_ready.
  initial begin
    logic [N-1:0] acc;
    logic [2*W-1:0] e;
    req_valid = '0;
    req_m = '0;
    req_q = '0;
    rsp_ready = '1;
    forever begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          e = rq[i][0];
          req_valid[i] = 1'b1;
          req_m[i*W +: W] = e[2*W-1:W];
          req_q[i*W +: W] = e[W-1:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = (rand_rsp ? N'($urandom) : {N{1'b1}}) & ~rsp_hold;
    end
  end

  // Datapath model: strobes sampled mid-cycle, applied at the rising edge.
  initial begin
    logic ld, ad, sh;
    logic [W-1:0] mm, qq;
    logic [W:0] sum;
    a_r = '0;
    q_r = '0;
    c_r = 1'b0;
    forever begin
      @(negedge clock);
      ld = dp_load; ad = dp_add; sh = dp_shift; mm = dp_m; qq = dp_q;
      @(posedge clock);
      if (ld) begin
        a_r = '0; c_r = 1'b0; q_r = qq;
      end else if (ad) begin
        sum = {1'b0, a_r} + {1'b0, mm};
        {c_r, a_r} = sum;
      end else if (sh) begin
        {c_r, a_r, q_r} = {1'b0, c_r, a_r, q_r[W-1:1]};
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int cyc = 0, acc_cyc = 0, n_shift = 0, n_add = 0, nstb;
    logic exp_busy = 1'b0;
    logic prev_rv = 1'b0;
    logic [N-1:0] acc, hs;
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        exp_busy = 1'b0;
        prev_rv  = 1'b0;
        continue;
      end
      nstb = int'(dp_load) + int'(dp_add) + int'(dp_shift);
      chk("strobe_count", 32'(nstb <= 1), 1);
      chk("busy", busy, exp_busy);
      if (!busy) chk("idle_strobes", nstb, 0);
      acc = req_valid & req_ready;
      hs  = rsp_valid & rsp_ready;
      if (dp_shift) n_shift++;
      if (dp_add) n_add++;
      if (rsp_valid != 0 && !prev_rv) chk("latency", cyc - acc_cyc, 2 * W + 3);
      prev_rv = (rsp_valid != 0);
      if (hs != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", hs, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_route", rsp_valid, 32'(1) << e.id);
          chk("rsp_product", rsp_product, e.p);
          chk("gnt_id", gnt_id, e.id);
          chk("shift_count", n_shift, W);
          chk("add_count", n_add, $countones(e.q));
        end
        exp_busy = 1'b0;
      end
      if (acc != 0) begin
        chk("accept_onehot", $countones(acc), 1);
        acc_cyc = cyc;
        n_shift = 0;
        n_add = 0;
        exp_busy = 1'b1;
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] m1, q1;
    reset = 1'b0;
    rsp_hold = '0;
    rand_rsp = 1'b0;
    model_last = N - 1;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_m", dp_m, 0);
    chk("rst_dp_q", dp_q, 0);
    chk("rst_strobes", {dp_load, dp_add, dp_shift}, 0);
    chk("rst_product", rsp_product, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);

    // Single request, then edge operands
    add_op(0, 8'h55, 8'h77);
    plan();
    chk("model_single", sb[0].p, 16'h2783);
    wait_done();
    add_op(0, 8'hFF, 8'hFF);
    add_op(0, 8'h00, 8'hAB);
    add_op(0, 8'h01, 8'h80);
    plan();
    wait_done();

    // Backpressure on requester 1 while requester 2 waits
    m1 = 8'hC3;
    q1 = 8'h5A;
    rsp_hold = 4'b0010;
    add_op(1, m1, q1);
    add_op(2, 8'h12, 8'h34);
    plan();
    n = 0;
    while (!rsp_valid[1] && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("bp_rsp_seen", rsp_valid[1], 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_product", rsp_product, 16'(int'(m1) * int'(q1)));
      chk("bp_no_grant", req_ready, 0);
      chk("bp_strobes", {dp_load, dp_add, dp_shift}, 0);
    end
    rsp_hold = '0;
    @(negedge clock);
    chk("bp_handshake", rsp_valid & rsp_ready, 4'b0010);
    @(negedge clock);
    chk("bp_next_accept", req_ready, 4'b0100);
    wait_done();

    // Reset mid-operation, not recorded in the scoreboard
    rq[0].push_back({8'h9D, 8'hE7});
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid_accept", req_ready[0], 1);
    repeat (6) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_gnt_id", gnt_id, 0);
    chk("rstmid_dp", {dp_m, dp_q}, 0);
    chk("rstmid_strobes", {dp_load, dp_add, dp_shift}, 0);
    chk("rstmid_product", rsp_product, 0);
    model_last = N - 1;

    // Arbitration: 0, 2, 3 held valid -> 0,2,3,0,2,3
    for (int r = 0; r < 2; r++) begin
      add_op(0, 8'(8'h11 + r), 8'h0F);
      add_op(2, 8'(8'h22 + r), 8'hF0);
      add_op(3, 8'(8'h33 + r), 8'hAA);
    end
    plan();
    chk("model_order", {8'(sb[0].id), 8'(sb[1].id), 8'(sb[2].id), 8'(sb[3].id)},
        32'h00020300);
    wait_done();

    // Random operations with random response backpressure
    rand_rsp = 1'b1;
    for (int k = 0; k < 50; k++) begin
      add_op(int'($urandom_range(0, N - 1)), 8'($urandom), 8'($urandom));
    end
    plan();
    wait_done();
    rand_rsp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one 8-bit shift-add multiplier datapath among several requesters. Each requester offers a multiplicand/multiplier pair over a valid/ready handshake. The block grants one request at a time and sequences the datapath through load, add and shift steps for a fixed number of cycles. It then returns the 16-bit product to the granted requester over a held response handshake. It sits between the requesting logic and the adder/register datapath, and replaces the single-user sequencer when the multiplier is shared.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 8: operand width; the product is 2W.
- clock  in  1  system clock (the slow clock from the counter); all state changes on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept pulse; a request is accepted when valid&ready are both high.
- req_m  in  N_REQ*W  multiplicands; slice i is bits [i*W +: W].
- req_q  in  N_REQ*W  multipliers; packed the same way as req_m.
- rsp_valid  out  N_REQ  one-hot response valid, routed to the owner of the current operation.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_product  out  2W  product, shared by all requesters; valid only while a rsp_valid bit is high.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  $clog2(N_REQ)  index of the current or most recent grant.
- dp_load  out  1  datapath: A<=0, C<=0, Q<=dp_q.
- dp_add  out  1  datapath: {C,A}<=A+M.
- dp_shift  out  1  datapath: {C,A,Q} shifted right by 1.
- dp_m, dp_q  out  W each  operands latched at acceptance; held constant until the next acceptance.
- dp_q0  in  1  current Q[0] from the datapath.
- dp_aq  in  2W  current {A,Q} from the datapath.

## Operation
- The states are IDLE, LOAD, ADD, SHIFT, CAPTURE and RESP.
- IDLE: the block scans req_valid round-robin, starting at index last_gnt+1 and wrapping. The winner w gets req_ready[w]=1 for that cycle. The block then latches req_m/req_q slice w into dp_m/dp_q, sets gnt_id=w and last_gnt=w, and moves to LOAD. With no valid request it stays in IDLE and all req_ready bits are 0.
- LOAD: dp_load=1 for one cycle. The bit counter is cleared to 0. Next state is ADD.
- ADD: dp_add=dp_q0, so the add happens only when Q[0]=1. The step always lasts one cycle. Next state is SHIFT.
- SHIFT: dp_shift=1 and the bit counter increments. If the counter was W-1, next state is CAPTURE; otherwise next state is ADD.
- CAPTURE: the result register takes dp_aq. Next state is RESP.
- RESP: rsp_valid[gnt_id]=1 and rsp_product=result, both held until rsp_ready[gnt_id]=1. On that handshake the next state is IDLE. rsp_ready bits of other requesters are ignored.
- At most one of dp_load, dp_add and dp_shift is high in any cycle. All three are 0 in IDLE, CAPTURE and RESP.
- Requesters must hold req_valid and their operands until accepted. A request never loses its turn: the worst-case wait is N_REQ-1 full operations.
- Simultaneous requests: the lowest index at or after last_gnt+1 (mod N_REQ) wins.
- A requester may hold req_valid during its own RESP. It is then eligible again in the next IDLE, after all other pending requesters in round-robin order.

## Timing
- Acceptance happens in cycle T (IDLE). LOAD is T+1. Bit i uses ADD at T+2+2i and SHIFT at T+3+2i. CAPTURE is T+2W+2 (T+18 for W=8). rsp_valid first rises at T+2W+3 (T+19).
- Latency is fixed and independent of the operand values.
- The RESP handshake happens in cycle R. The block is in IDLE at R+1, and the earliest next acceptance is R+1.
- Reset values: state=IDLE, last_gnt=N_REQ-1 (so requester 0 wins first), gnt_id=0, result=0, dp_m=0, dp_q=0, busy=0. All req_ready, rsp_valid and dp_* strobes are 0.
- Reset mid-operation (any state): the in-flight operation is abandoned and no response is issued. The requester must re-request.
- Operands are unsigned. The product is exact in 2W bits: for W=8 the maximum is 0xFF*0xFF = 0xFE01.

## Test plan
- The bench pairs the block with a behavioural shift-add datapath model.
- Single request: req 0 with m=0x55, q=0x77 -> req_ready[0] pulses in cycle T; rsp_valid[0] at T+19; rsp_product=0x2783.
- Edge operands: 0xFF*0xFF -> 0xFE01. 0x00*0xAB -> 0x0000. 0x01*0x80 -> 0x0080. In every case exactly 8 dp_shift pulses, and dp_add count equals popcount(q).
- Arbitration: requesters 0, 2 and 3 all assert valid from reset and hold -> grant order is 0, 2, 3, 0, ... . gnt_id matches the order, and each response is routed only to its owner.
- Backpressure: rsp_ready[1] held low for 10 cycles in RESP -> rsp_valid[1] and rsp_product stay stable, no new grant occurs, and all dp_* strobes stay 0. Acceptance follows in the cycle after the handshake.
- Reset mid-operation: reset=0 at T+6 -> next cycle is IDLE with all outputs at reset values and no rsp_valid. After reset rises, requester 0 is granted first.
- Strobe check over 50 random operations: at most one dp_* strobe per cycle, and busy is high exactly from T+1 to R.
